lag_filter_mc: RTL and testbench
================================

# lag_filter_mc

Multi-channel, time-multiplexed first-order lag (low-pass) filter. It is the parametrised successor of the single-channel lag filter. One shared multiplier serves `CHANNELS` independent state accumulators, each implementing y[n] = y[n-1] + k·(x[n] − y[n-1]) with k = coef/2^COEF_WIDTH. It adds a runtime-loadable coefficient, valid/ready input handshake, per-sample channel tag, bypass mode, bulk clear, and output saturation. It sits between the ADC/demodulator sample stream and downstream control/measurement logic.

## Interface
- `WIDTH`, 24, signed sample width (in and out)
- `COEF_WIDTH`, 24, unsigned coefficient width; k = coef/2^COEF_WIDTH, range [0, 1)
- `CHANNELS`, 4, number of independent filter states, 1..16
- `COEF_INIT`, 1, coefficient register value after reset
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `coef_i`  in  COEF_WIDTH  new coefficient value
- `coef_load`  in  1  load `coef_i` into coefficient register
- `bypass`  in  1  1 = pass-through mode, sampled at compute cycle
- `clear`  in  1  zero all channel states, abort pending sample
- `in_valid`  in  1  input sample valid
- `in_ready`  out  1  block can accept a sample
- `in_ch`  in  clog2(CHANNELS) (min 1)  channel tag of input sample
- `data_i`  in  WIDTH  signed input sample
- `out_valid`  out  1  one-cycle pulse, result valid
- `out_ch`  out  clog2(CHANNELS) (min 1)  channel tag of result
- `data_o`  out  WIDTH  signed filtered output
- `ch_err`  out  1  sticky: a sample arrived with `in_ch` ≥ CHANNELS

## Operation
- State per channel: acc[c], signed, WIDTH+COEF_WIDTH bits; y[c] = acc[c] >>> COEF_WIDTH (arithmetic, floor).
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid` the sample is accepted: x, ch and y[ch] are latched, and the FSM goes to CALC.
  - CALC: `in_ready`=0. Compute diff = x − y (WIDTH+1 bits) and prod = coef·diff (WIDTH+COEF_WIDTH+2 bits, coef zero-extended). sum = acc[ch] + prod, then clamp to [−2^(WIDTH−1)·2^COEF_WIDTH, (2^(WIDTH−1))·2^COEF_WIDTH − 1]. Write sum to acc[ch], set data_o = sum >>> COEF_WIDTH, assert out_valid, return to IDLE.
- Bypass (sampled in CALC): data_o = x and acc[ch] = x << COEF_WIDTH, so leaving bypass causes no step.
- Out-of-range `in_ch`: the handshake completes normally. In CALC there is no state write and no `out_valid`, and `ch_err` is set.
- `coef_load`: the register updates at the next edge. A compute occurring on that same edge uses the old value.
- `clear`: at the next edge all acc are set to 0, `ch_err` is set to 0, and the FSM goes to IDLE. If in CALC, the pending sample is dropped with no `out_valid`. `clear` takes priority over `in_valid` acceptance; `rst` takes priority over everything.
- `data_o`/`out_ch` hold their last values while `out_valid`=0.
- There is no output backpressure; the consumer must take `out_valid` pulses.

## Timing
- Reset values: `in_ready`=0 during reset, 1 in the first cycle after; `out_valid`=0, `data_o`=0, `out_ch`=0, `ch_err`=0, all acc=0, coef=COEF_INIT, FSM=IDLE.
- Accept at edge E0 (`in_valid`&`in_ready`). The result is registered at E1: `out_valid`=1 for the cycle after E1.
- Latency is 1 edge from acceptance to registered result.
- Throughput is 1 sample per 2 cycles. `in_ready` is low for exactly the one cycle after acceptance.
- A new sample for the same channel accepted at E1 already sees the updated acc, so there is no hazard.
- `rst` asserted mid-CALC: the result is discarded and all state is set to its reset values at that edge.

## Test plan
- Step, ch0, coef=0x800000 (k=0.5), data_i=1000 repeated → data_o 500, 750, 875, 937, 969; out_ch=0 each time; `in_ready` toggles 1/0.
- Negative step, ch1, same coef, data_i=−1000 → −500, −750, −875, −938 (floor). Channel 0 state is unaffected: the next ch0 sample of 1000 after the sequence above yields 984.
- Interleaved ch0=1000 and ch3=−1000, coef=0x400000 (k=0.25) → ch0 gives 250, 437; ch3 gives −250, −438; out_ch tags match. `coef_load` of 0x800000 coincident with a CALC edge: that result still uses k=0.25, and the next sample uses 0.5.
- Extremes: coef=0xFFFFFF, alternate data_i=+8388607 and −8388608 on ch2 → data_o always within [−8388608, 8388607]; first output 8388606.
- Bypass, then clear:
  - With `bypass`=1, data_i=1234 on ch0 → data_o=1234. With bypass then 0 and k=0.5, data_i=1234 → 1234 (no step).
  - `clear` asserted during CALC → no `out_valid`, and the next ch0 sample of 1000 → 500.
- Out-of-range channel, CHANNELS=3: in_ch=3 → no `out_valid` and `ch_err`=1, sticky until `clear`. Reset mid-stream → all outputs 0; then data_i=1000 with COEF_INIT=1 → data_o=0.

Source files
------------

// File: rtl/lag_filter_mc.sv
// Multi-channel, time-multiplexed first-order lag filter: y += k*(x - y), k = coef/2^COEF_WIDTH.
// One shared multiplier serves CHANNELS accumulators; one sample is accepted every two cycles.
module lag_filter_mc #(
  parameter int WIDTH      = 24,
  parameter int COEF_WIDTH = 24,
  parameter int CHANNELS   = 4,
  parameter logic [COEF_WIDTH-1:0] COEF_INIT = COEF_WIDTH'(1),
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COEF_WIDTH-1:0]   coef_i,
  input  logic                    coef_load,
  input  logic                    bypass,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [WIDTH-1:0] data_i,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [WIDTH-1:0] data_o,
  output logic                    ch_err
);

  localparam int AW = WIDTH + COEF_WIDTH;  // accumulator: y in the top WIDTH bits
  localparam int PW = AW + 2;              // coef (unsigned) times diff (WIDTH+1 signed)
  localparam int SW = AW + 3;              // acc + prod without wrap
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t                  state;
  logic [COEF_WIDTH-1:0]   coef;
  logic signed [WIDTH-1:0] x_q;
  logic signed [WIDTH-1:0] y_q;
  logic [CH_W-1:0]         ch_q;
  logic                    ch_ok_q;
  logic signed [AW-1:0]    acc [CHANNELS];

  logic                    in_ok;
  logic signed [AW-1:0]    acc_cur;
  logic signed [WIDTH:0]   diff;
  logic signed [PW-1:0]    prod;
  logic signed [SW-1:0]    sum;
  logic signed [AW-1:0]    sum_sat;

  assign in_ready = (state == S_IDLE) && !rst;
  assign in_ok    = ({1'b0, in_ch} < CH_LIM);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_cur = '0;
    if (ch_ok_q) acc_cur = acc[ch_q];
    diff = {x_q[WIDTH-1], x_q} - {y_q[WIDTH-1], y_q};
    prod = $signed({1'b0, coef}) * diff;
    sum  = SW'(acc_cur) + SW'(prod);
    // In range when all bits above the accumulator sign bit agree with it.
    sum_sat = sum[AW-1:0];
    if (sum[SW-1:AW-1] != {(SW-AW+1){sum[SW-1]}}) begin
      sum_sat = sum[SW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
  end

  // NOTE: acc is reset and bulk-cleared in one cycle, so it must be built from flops rather than a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      coef      <= COEF_INIT;
      out_valid <= 1'b0;
      out_ch    <= '0;
      data_o    <= '0;
      ch_err    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      ch_q      <= '0;
      ch_ok_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else begin
      out_valid <= 1'b0;
      // A compute on this same edge still sees the old coef.
      if (coef_load) coef <= coef_i;
      if (clear) begin
        state  <= S_IDLE;
        ch_err <= 1'b0;
        for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (in_valid) begin
              x_q     <= data_i;
              ch_q    <= in_ch;
              ch_ok_q <= in_ok;
              y_q     <= in_ok ? acc[in_ch][AW-1:COEF_WIDTH] : '0;
              state   <= S_CALC;
            end
          end
          S_CALC: begin
            state <= S_IDLE;
            if (!ch_ok_q) begin
              ch_err <= 1'b1;
            end else begin
              out_valid <= 1'b1;
              out_ch    <= ch_q;
              if (bypass) begin
                // Load the state with x so leaving bypass causes no step.
                data_o     <= x_q;
                acc[ch_q]  <= {x_q, {COEF_WIDTH{1'b0}}};
              end else begin
                data_o     <= sum_sat[AW-1:COEF_WIDTH];
                acc[ch_q]  <= sum_sat;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lag_filter_mc.sv
// Directed bench for lag_filter_mc: a 4-channel and a 3-channel instance share one stimulus stream.
module tb_lag_filter_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] coef_i;
  logic        coef_load;
  logic        bypass;
  logic        clear;
  logic        in_valid;
  logic [1:0]  in_ch;
  logic signed [23:0] data_i;

  logic        in_ready, out_valid, ch_err;
  logic [1:0]  out_ch;
  logic signed [23:0] data_o;

  logic        in_ready3, out_valid3, ch_err3;
  logic [1:0]  out_ch3;
  logic signed [23:0] data_o3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lag_filter_mc #(.WIDTH(24), .COEF_WIDTH(24), .CHANNELS(4), .COEF_INIT(24'd1)) dut (
    .clk(clk), .rst(rst), .coef_i(coef_i), .coef_load(coef_load), .bypass(bypass),
    .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .data_i(data_i), .out_valid(out_valid), .out_ch(out_ch), .data_o(data_o),
    .ch_err(ch_err)
  );

  lag_filter_mc #(.WIDTH(24), .COEF_WIDTH(24), .CHANNELS(3), .COEF_INIT(24'd1)) dut3 (
    .clk(clk), .rst(rst), .coef_i(coef_i), .coef_load(coef_load), .bypass(bypass),
    .clear(clear), .in_valid(in_valid), .in_ready(in_ready3), .in_ch(in_ch),
    .data_i(data_i), .out_valid(out_valid3), .out_ch(out_ch3), .data_o(data_o3),
    .ch_err(ch_err3)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_coef(input logic [23:0] c);
    coef_i    = c;
    coef_load = 1'b1;
    @(posedge clk); #1;
    coef_load = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // Called one time unit after a rising edge with the DUTs idle.
  task automatic send(input string tag, input logic [1:0] ch, input int x,
                      input bit sel3, input bit exp_valid, input int exp_data,
                      input bit load_mid, input logic [23:0] mid_coef, input bit clr_mid);
    check({tag, "_ready"}, sel3 ? in_ready3 : in_ready, 1);
    in_valid = 1'b1;
    in_ch    = ch;
    data_i   = 24'(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, sel3 ? in_ready3 : in_ready, 0);
    if (load_mid) begin
      coef_i    = mid_coef;
      coef_load = 1'b1;
    end
    if (clr_mid) clear = 1'b1;
    @(posedge clk); #1;
    coef_load = 1'b0;
    clear     = 1'b0;
    if (sel3) begin
      check({tag, "_valid"}, out_valid3, exp_valid);
      if (exp_valid) begin
        check({tag, "_data"}, data_o3, exp_data);
        check({tag, "_ch"}, out_ch3, ch);
      end
    end else begin
      check({tag, "_valid"}, out_valid, exp_valid);
      if (exp_valid) begin
        check({tag, "_data"}, data_o, exp_data);
        check({tag, "_ch"}, out_ch, ch);
      end
    end
  endtask

  int step_exp [5] = '{500, 750, 875, 937, 969};
  int neg_exp  [4] = '{-500, -750, -875, -938};
  int ext_exp  [4] = '{8388606, -8388607, 8388606, -8388607};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; coef_i = '0; coef_load = 1'b0; bypass = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_ch = '0; data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", data_o, 0);
    check("rst_ch", out_ch, 0);
    check("rst_err", ch_err, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);

    // Step response, k = 0.5
    load_coef(24'h800000);
    for (int i = 0; i < 5; i++) send($sformatf("step%0d", i), 2'd0, 1000, 0, 1, step_exp[i], 0, '0, 0);

    // Negative step on ch1; ch0 keeps its own state
    for (int i = 0; i < 4; i++) send($sformatf("neg%0d", i), 2'd1, -1000, 0, 1, neg_exp[i], 0, '0, 0);
    send("ch0_resume", 2'd0, 1000, 0, 1, 984, 0, '0, 0);

    // Interleaved channels, k = 0.25, coef change landing on a compute edge
    do_clear();
    load_coef(24'h400000);
    send("il_ch0_a", 2'd0, 1000, 0, 1, 250, 0, '0, 0);
    send("il_ch3_a", 2'd3, -1000, 0, 1, -250, 0, '0, 0);
    send("il_ch0_b", 2'd0, 1000, 0, 1, 437, 0, '0, 0);
    send("il_ch3_b", 2'd3, -1000, 0, 1, -438, 1, 24'h800000, 0);
    send("il_newk", 2'd0, 1000, 0, 1, 719, 0, '0, 0);
    check("il_no_err", ch_err, 0);

    // Full-scale alternation with the largest coefficient
    do_clear();
    load_coef(24'hFFFFFF);
    for (int i = 0; i < 4; i++)
      send($sformatf("ext%0d", i), 2'd2, (i % 2 == 0) ? 8388607 : -8388608, 0, 1, ext_exp[i], 0, '0, 0);

    // Bypass, then normal filtering without a step, then clear during compute
    do_clear();
    load_coef(24'h800000);
    bypass = 1'b1;
    send("byp_on", 2'd0, 1234, 0, 1, 1234, 0, '0, 0);
    bypass = 1'b0;
    send("byp_off", 2'd0, 1234, 0, 1, 1234, 0, '0, 0);
    send("clr_calc", 2'd0, 1000, 0, 0, 0, 0, '0, 1);
    check("clr_hold_data", data_o, 1234);
    send("clr_after", 2'd0, 1000, 0, 1, 500, 0, '0, 0);

    // Out-of-range channel on the 3-channel instance
    send("oor", 2'd3, 1000, 1, 0, 0, 0, '0, 0);
    check("oor_err", ch_err3, 1);
    send("oor_sticky", 2'd0, 1000, 1, 1, 750, 0, '0, 0);
    check("oor_err_sticky", ch_err3, 1);
    do_clear();
    check("oor_err_clr", ch_err3, 0);

    // Reset while a sample is in compute
    send("pre_rst", 2'd1, 1000, 1, 1, 500, 0, '0, 0);
    in_valid = 1'b1; in_ch = 2'd1; data_i = 24'sd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", data_o, 0);
    check("mid_rst_ch", out_ch, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_valid3", out_valid3, 0);
    check("mid_rst_data3", data_o3, 0);
    check("mid_rst_ch3", out_ch3, 0);
    rst = 1'b0;
    #1;
    send("coef_init", 2'd0, 1000, 0, 1, 0, 0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
